// File: rtl/servo_lock_sequencer_if.sv
// Control bundle between the lock sequencer and the PID/sweep blocks:
// coefficient-update handshake plus the servo enable/clear/hold lines.
interface servo_lock_sequencer_if;
  logic param_req;
  logic param_apply;
  logic pid_on;
  logic pid_clear;
  logic sweep_hold;

  modport master (
    input  param_req,
    output param_apply,
    output pid_on,
    output pid_clear,
    output sweep_hold
  );

  modport slave (
    output param_req,
    input  param_apply,
    input  pid_on,
    input  pid_clear,
    input  sweep_hold
  );
endinterface

// File: rtl/servo_lock_sequencer.sv
// Lock-acquisition sequencer for the laser servo: debounced threshold FSM
// driving sweep/PID control, coefficient-update gating and status LEDs.
module servo_lock_sequencer #(
  parameter int unsigned DEBOUNCE      = 16,
  parameter int unsigned RECENT_CYCLES = 100000000
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                enable_in,
  input  logic signed [15:0]  trans_in,
  input  logic signed [15:0]  thr_hi_in,
  input  logic signed [15:0]  thr_lo_in,
  input  logic [27:0]         settle_cycles_in,
  input  logic [7:0]          max_attempts_in,
  input  logic                clear_fault_in,
  servo_lock_sequencer_if.master ctl,
  output logic [2:0]          state_out,
  output logic [7:0]          attempts_out,
  output logic                fault_out,
  output logic                locked_led_out,
  output logic                unlocked_led_out,
  output logic                recent_led_out
);

  localparam int unsigned DW = $clog2(DEBOUNCE + 1);
  localparam int unsigned RW = (RECENT_CYCLES < 2) ? 1 : $clog2(RECENT_CYCLES + 1);
  localparam logic [DW-1:0] DEB_MAX     = DW'(DEBOUNCE);
  localparam logic [DW-1:0] DEB_LAST    = DW'(DEBOUNCE - 1);
  localparam logic [RW-1:0] RECENT_LOAD = RW'(RECENT_CYCLES);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SWEEP   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_LOCKED  = 3'd3,
    ST_FAULT   = 3'd4
  } state_t;

  state_t             state_reg, state_next;
  logic signed [15:0] trans_reg;
  logic [DW-1:0]      deb_cnt_reg, deb_cnt_next;
  logic [27:0]        settle_cnt_reg, settle_cnt_next;
  logic [28:0]        settle_inc;
  logic [RW-1:0]      recent_cnt_reg, recent_cnt_next;
  logic [7:0]         attempts_reg, attempts_next, attempts_inc;
  logic               pending_reg, pending_next, apply_fire;
  logic               deb_qual, deb_hit, settle_done, state_change;
  logic               pid_on_reg, pid_clear_reg, sweep_hold_reg, param_apply_reg, fault_reg;
  logic               locked_led_reg, unlocked_led_reg, recent_led_reg;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) trans_reg <= '0;
    else        trans_reg <= trans_in;
  end

  // The qualifying condition depends on which way the current state can exit.
  always_comb begin
    deb_qual = 1'b0;
    case (state_reg)
      ST_SWEEP:              deb_qual = (trans_reg >= thr_hi_in);
      ST_CAPTURE, ST_LOCKED: deb_qual = (trans_reg < thr_lo_in);
      default:               deb_qual = 1'b0;
    endcase
  end

  assign deb_hit      = deb_qual && (deb_cnt_reg >= DEB_LAST);
  assign settle_inc   = {1'b0, settle_cnt_reg} + 29'd1;
  assign settle_done  = (settle_inc >= {1'b0, settle_cycles_in});
  assign attempts_inc = (attempts_reg == 8'hFF) ? 8'hFF : attempts_reg + 8'd1;

  always_comb begin
    state_next    = state_reg;
    attempts_next = attempts_reg;
    case (state_reg)
      ST_IDLE: begin
        if (enable_in) state_next = ST_SWEEP;
      end
      ST_SWEEP: begin
        if (!enable_in)   state_next = ST_IDLE;
        else if (deb_hit) state_next = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (!enable_in) begin
          state_next = ST_IDLE;
        end else if (deb_hit) begin
          attempts_next = attempts_inc;
          if ((max_attempts_in != 8'd0) && (attempts_inc == max_attempts_in))
            state_next = ST_FAULT;
          else
            state_next = ST_SWEEP;
        end else if (settle_done) begin
          state_next    = ST_LOCKED;
          attempts_next = 8'd0;
        end
      end
      ST_LOCKED: begin
        if (!enable_in)   state_next = ST_IDLE;
        else if (deb_hit) state_next = ST_SWEEP;
      end
      ST_FAULT: begin
        if (clear_fault_in) begin
          state_next    = ST_IDLE;
          attempts_next = 8'd0;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign state_change = (state_next != state_reg);

  always_comb begin
    deb_cnt_next = '0;
    if (!state_change && deb_qual)
      deb_cnt_next = (deb_cnt_reg == DEB_MAX) ? DEB_MAX : deb_cnt_reg + DW'(1);
  end

  assign settle_cnt_next = ((state_reg == ST_CAPTURE) && (state_next == ST_CAPTURE))
                           ? settle_inc[27:0] : 28'd0;

  always_comb begin
    recent_cnt_next = '0;
    if ((state_reg == ST_LOCKED) && (state_next != ST_LOCKED))
      recent_cnt_next = '0;
    else if ((state_reg == ST_CAPTURE) && (state_next == ST_LOCKED))
      recent_cnt_next = RECENT_LOAD;
    else if (recent_cnt_reg != '0)
      recent_cnt_next = recent_cnt_reg - RW'(1);
  end

  // Coefficients never change underneath a capture in progress.
  assign apply_fire   = pending_reg && (state_next != ST_CAPTURE);
  assign pending_next = apply_fire ? 1'b0 : (pending_reg | ctl.param_req);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_reg        <= ST_IDLE;
      deb_cnt_reg      <= '0;
      settle_cnt_reg   <= '0;
      recent_cnt_reg   <= '0;
      attempts_reg     <= 8'd0;
      pending_reg      <= 1'b0;
      pid_on_reg       <= 1'b0;
      pid_clear_reg    <= 1'b0;
      sweep_hold_reg   <= 1'b1;
      param_apply_reg  <= 1'b0;
      fault_reg        <= 1'b0;
      locked_led_reg   <= 1'b1;
      unlocked_led_reg <= 1'b1;
      recent_led_reg   <= 1'b1;
    end else begin
      state_reg        <= state_next;
      deb_cnt_reg      <= deb_cnt_next;
      settle_cnt_reg   <= settle_cnt_next;
      recent_cnt_reg   <= recent_cnt_next;
      attempts_reg     <= attempts_next;
      pending_reg      <= pending_next;
      pid_on_reg       <= (state_next == ST_CAPTURE) || (state_next == ST_LOCKED);
      pid_clear_reg    <= (state_reg == ST_SWEEP) && (state_next == ST_CAPTURE);
      sweep_hold_reg   <= (state_next != ST_SWEEP);
      param_apply_reg  <= apply_fire;
      fault_reg        <= (state_next == ST_FAULT);
      locked_led_reg   <= !(state_next == ST_LOCKED);
      unlocked_led_reg <= !((state_next == ST_SWEEP) || (state_next == ST_CAPTURE) ||
                            (state_next == ST_FAULT));
      recent_led_reg   <= (recent_cnt_next == '0);
    end
  end

  assign state_out        = state_reg;
  assign attempts_out     = attempts_reg;
  assign fault_out        = fault_reg;
  assign locked_led_out   = locked_led_reg;
  assign unlocked_led_out = unlocked_led_reg;
  assign recent_led_out   = recent_led_reg;
  assign ctl.pid_on       = pid_on_reg;
  assign ctl.pid_clear    = pid_clear_reg;
  assign ctl.sweep_hold   = sweep_hold_reg;
  assign ctl.param_apply  = param_apply_reg;

endmodule

// File: tb/tb_servo_lock_sequencer.sv
// Directed bench for servo_lock_sequencer: debounce timing, settle, attempts/fault,
// parameter gating, LED timing and asynchronous reset.
module tb_servo_lock_sequencer;
  logic               clk_in = 1'b0;
  logic               rst_in;
  logic               enable_in;
  logic signed [15:0] trans_in, thr_hi_in, thr_lo_in;
  logic [27:0]        settle_cycles_in;
  logic [7:0]         max_attempts_in;
  logic               clear_fault_in;
  logic [2:0]         state_out;
  logic [7:0]         attempts_out;
  logic               fault_out, locked_led_out, unlocked_led_out, recent_led_out;

  int checks = 0;
  int passed = 0;

  servo_lock_sequencer_if ctl();

  servo_lock_sequencer #(.DEBOUNCE(16), .RECENT_CYCLES(40)) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .enable_in        (enable_in),
    .trans_in         (trans_in),
    .thr_hi_in        (thr_hi_in),
    .thr_lo_in        (thr_lo_in),
    .settle_cycles_in (settle_cycles_in),
    .max_attempts_in  (max_attempts_in),
    .clear_fault_in   (clear_fault_in),
    .ctl              (ctl),
    .state_out        (state_out),
    .attempts_out     (attempts_out),
    .fault_out        (fault_out),
    .locked_led_out   (locked_led_out),
    .unlocked_led_out (unlocked_led_out),
    .recent_led_out   (recent_led_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  initial begin
    logic clr_seen;
    logic apply_seen;

    rst_in = 1'b1; enable_in = 1'b0; trans_in = 16'sd0;
    thr_hi_in = 16'sd1000; thr_lo_in = 16'sd500;
    settle_cycles_in = 28'd100; max_attempts_in = 8'd0;
    clear_fault_in = 1'b0; ctl.param_req = 1'b0;
    tick(2);
    chk("rst_state",    32'(state_out), 32'd0);
    chk("rst_hold",     32'(ctl.sweep_hold), 32'd1);
    chk("rst_pid_on",   32'(ctl.pid_on), 32'd0);
    chk("rst_apply",    32'(ctl.param_apply), 32'd0);
    chk("rst_attempts", 32'(attempts_out), 32'd0);
    chk("rst_leds",     32'({locked_led_out, unlocked_led_out, recent_led_out}), 32'd7);
    rst_in = 1'b0;

    // Parameter request in IDLE: pending on the first edge, apply on the second.
    ctl.param_req = 1'b1;
    tick(1);
    chk("idle_apply_e1", 32'(ctl.param_apply), 32'd0);
    ctl.param_req = 1'b0;
    tick(1);
    chk("idle_apply_e2", 32'(ctl.param_apply), 32'd1);
    tick(1);
    chk("idle_apply_e3", 32'(ctl.param_apply), 32'd0);

    // 15 qualifying samples then a miss: no capture.
    enable_in = 1'b1; trans_in = 16'sd1200;
    tick(1);
    chk("sweep_entry", 32'(state_out), 32'd1);
    chk("sweep_hold0", 32'(ctl.sweep_hold), 32'd0);
    clr_seen = ctl.pid_clear;
    for (int i = 0; i < 14; i++) begin
      tick(1);
      clr_seen |= ctl.pid_clear;
    end
    trans_in = 16'sd0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      clr_seen |= ctl.pid_clear;
    end
    chk("short_burst_state", 32'(state_out), 32'd1);
    chk("short_burst_clear", 32'(clr_seen), 32'd0);

    // Full debounce: capture on the 17th edge after the first qualifying sample.
    trans_in = 16'sd1200;
    tick(16);
    chk("deb16_state", 32'(state_out), 32'd1);
    tick(1);
    chk("capture_state", 32'(state_out), 32'd2);
    chk("capture_clear", 32'(ctl.pid_clear), 32'd1);
    chk("capture_pid_on", 32'(ctl.pid_on), 32'd1);
    chk("capture_hold", 32'(ctl.sweep_hold), 32'd1);

    // Request during CAPTURE is deferred to LOCKED entry (100 cycles after capture).
    ctl.param_req = 1'b1;
    tick(1);
    chk("clear_one_cycle", 32'(ctl.pid_clear), 32'd0);
    ctl.param_req = 1'b0;
    apply_seen = ctl.param_apply;
    for (int i = 0; i < 98; i++) begin
      tick(1);
      apply_seen |= ctl.param_apply;
    end
    chk("settle_99_state", 32'(state_out), 32'd2);
    chk("capture_no_apply", 32'(apply_seen), 32'd0);
    tick(1);
    chk("locked_state", 32'(state_out), 32'd3);
    chk("locked_apply", 32'(ctl.param_apply), 32'd1);
    chk("locked_leds", 32'({locked_led_out, unlocked_led_out, recent_led_out}), 32'd2);
    chk("locked_attempts", 32'(attempts_out), 32'd0);
    tick(1);
    chk("apply_one_cycle", 32'(ctl.param_apply), 32'd0);
    tick(38);
    chk("recent_still_on", 32'(recent_led_out), 32'd0);
    tick(1);
    chk("recent_off", 32'(recent_led_out), 32'd1);

    // Lock loss from LOCKED returns to SWEEP, attempts untouched.
    trans_in = 16'sd0;
    tick(16);
    chk("loss16_state", 32'(state_out), 32'd3);
    tick(1);
    chk("loss_sweep", 32'(state_out), 32'd1);
    chk("loss_pid_on", 32'(ctl.pid_on), 32'd0);
    chk("loss_attempts", 32'(attempts_out), 32'd0);

    // Three failed captures with max_attempts=3 end in FAULT.
    max_attempts_in = 8'd3; settle_cycles_in = 28'd1000;
    for (int i = 1; i <= 3; i++) begin
      trans_in = 16'sd1200;
      tick(20);
      chk($sformatf("try%0d_capture", i), 32'(state_out), 32'd2);
      trans_in = 16'sd0;
      tick(20);
      chk($sformatf("try%0d_state", i), 32'(state_out), (i < 3) ? 32'd1 : 32'd4);
      chk($sformatf("try%0d_attempts", i), 32'(attempts_out), 32'(i));
    end
    chk("fault_flag", 32'(fault_out), 32'd1);
    chk("fault_pid_on", 32'(ctl.pid_on), 32'd0);
    chk("fault_unlocked_led", 32'(unlocked_led_out), 32'd0);
    tick(3);
    chk("fault_sticky", 32'(state_out), 32'd4);
    clear_fault_in = 1'b1;
    tick(1);
    clear_fault_in = 1'b0;
    chk("clear_idle", 32'(state_out), 32'd0);
    chk("clear_attempts", 32'(attempts_out), 32'd0);
    chk("clear_fault_flag", 32'(fault_out), 32'd0);
    tick(1);
    chk("clear_resweep", 32'(state_out), 32'd1);

    // enable drop on the edge that would have captured wins.
    trans_in = 16'sd1200;
    tick(16);
    chk("pre_disable_state", 32'(state_out), 32'd1);
    enable_in = 1'b0;
    tick(1);
    chk("disable_idle", 32'(state_out), 32'd0);
    chk("disable_no_clear", 32'(ctl.pid_clear), 32'd0);

    // settle=0 locks after a single CAPTURE cycle.
    settle_cycles_in = 28'd0; enable_in = 1'b1;
    tick(17);
    chk("s0_capture", 32'(state_out), 32'd2);
    tick(1);
    chk("s0_locked", 32'(state_out), 32'd3);
    chk("s0_recent", 32'(recent_led_out), 32'd0);

    // Asynchronous reset in LOCKED, between clock edges.
    #2;
    rst_in = 1'b1;
    #1;
    chk("arst_state", 32'(state_out), 32'd0);
    chk("arst_pid_on", 32'(ctl.pid_on), 32'd0);
    chk("arst_hold", 32'(ctl.sweep_hold), 32'd1);
    chk("arst_leds", 32'({locked_led_out, unlocked_led_out, recent_led_out}), 32'd7);
    tick(1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
